priority_decoder_seq: RTL

PRIORITY_DECODER_SEQ -- requirements
Module: priority_decoder_seq

---
 rtl/priority_decoder_pkg.sv | 27 ++
 rtl/pd_hold_counter.sv | 46 ++++
 rtl/priority_decoder_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/priority_decoder_pkg.sv
// -----------------------------------------------------------------------------
// priority_decoder_pkg
// Shared types and constants for the priority_decoder_seq block:
//   - pd_state_e     : controller states IDLE / HOLD / GAP
//   - PD_*_DEF       : default values of the top-level parameters
//   - PD_CNT_W       : width of the hold/gap down-counter (covers 1..255)
//   - pd_code_w()    : encoded-index width for a given number of output lines
// -----------------------------------------------------------------------------
package priority_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } pd_state_e;

    localparam int PD_OUT_W_DEF = 4;
    localparam int PD_HOLD_DEF  = 3;
    localparam int PD_GAP_DEF   = 1;
    localparam int PD_CNT_W     = 8;

    // clog2 of the line count, never narrower than one bit.
    function automatic int pd_code_w(input int out_w);
        return (out_w <= 2) ? 1 : $clog2(out_w);
    endfunction

endpackage

// File: rtl/pd_hold_counter.sv
// -----------------------------------------------------------------------------
// pd_hold_counter
// Loadable down-counter that saturates at zero. Used to time both the HOLD
// and the GAP phases of priority_decoder_seq.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (counter -> 0)
//   load     in   load load_val this cycle (takes precedence over counting)
//   load_val in   value to load, CNT_W bits
//   zero     out  counter currently holds zero
// -----------------------------------------------------------------------------
module pd_hold_counter
    import priority_decoder_pkg::*;
#(
    parameter int CNT_W = PD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/priority_decoder_seq.sv
// -----------------------------------------------------------------------------
// priority_decoder_seq
// Takes an encoded "highest active line" request from a priority encoder and
// drives the matching one-hot output line for HOLD_CYCLES cycles, followed by
// GAP_CYCLES all-zero cycles, before accepting the next request. Requests with
// an out-of-range code are rejected with a one-cycle err pulse.
//
// Optional feature: define PRIORITY_DECODER_SEQ_PARITY_EN to add in_parity,
// an even-parity bit over {in_any, in_code}; a mismatch rejects the request.
//
// Parameters: OUT_W (2..16), HOLD_CYCLES (1..255), GAP_CYCLES (0..255)
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   request present
//   in_ready  out  block is IDLE and can accept a request
//   in_any    in   encoder reports some active line (0 -> decode to all-zero)
//   in_code   in   CODE_W-bit index of the highest-priority active line
//   in_parity in   (PARITY_EN only) even parity over {in_any, in_code}
//   dout      out  registered one-hot lines
//   done      out  one-cycle pulse in the last HOLD cycle
//   err       out  one-cycle pulse after a rejected request
// -----------------------------------------------------------------------------
module priority_decoder_seq
    import priority_decoder_pkg::*;
#(
    parameter int OUT_W       = PD_OUT_W_DEF,
    parameter int HOLD_CYCLES = PD_HOLD_DEF,
    parameter int GAP_CYCLES  = PD_GAP_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_any,
    input  logic [pd_code_w(OUT_W)-1:0]   in_code,
`ifdef PRIORITY_DECODER_SEQ_PARITY_EN
    input  logic                          in_parity,
`endif
    output logic [OUT_W-1:0]              dout,
    output logic                          done,
    output logic                          err
);

    localparam int CODE_W = pd_code_w(OUT_W);

    // One extra bit so OUT_W itself is representable for the range compare.
    localparam logic [CODE_W:0]     OUT_W_C = (CODE_W + 1)'(OUT_W);
    // Counters are loaded with N-1 so that zero marks the last cycle of a phase.
    localparam logic [PD_CNT_W-1:0] HOLD_LD = PD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PD_CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? PD_CNT_W'(GAP_CYCLES - 1) : '0;

    pd_state_e              state_q, state_d;
    logic [OUT_W-1:0]       dout_q, dout_d;
    logic                   err_q, err_d;
    logic                   done_c;
    logic                   cnt_load;
    logic [PD_CNT_W-1:0]    cnt_load_val;
    logic                   cnt_zero;
    logic [OUT_W-1:0]       onehot;
    logic                   code_oob;
    logic                   parity_bad;
    logic                   reject;
    logic                   accept;

    pd_hold_counter #(
        .CNT_W (PD_CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // Decode compares against each index so an out-of-range code simply
    // yields no set bit instead of indexing past the vector.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = in_any && (in_code == CODE_W'(i));
        end
    end

    // in_code only matters when in_any is set.
    assign code_oob = in_any && ({1'b0, in_code} >= OUT_W_C);

`ifdef PRIORITY_DECODER_SEQ_PARITY_EN
    assign parity_bad = (in_parity != ^{in_any, in_code});
`else
    assign parity_bad = 1'b0;
`endif

    assign reject   = code_oob | parity_bad;
    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        err_d        = 1'b0;
        done_c       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        // Consumed without leaving IDLE.
                        err_d = 1'b1;
                    end else begin
                        state_d      = HOLD;
                        dout_d       = onehot;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LD;
                    end
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    done_c = 1'b1;
                    dout_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d      = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign dout = dout_q;
    assign done = done_c;
    assign err  = err_q;

endmodule
